// File: rtl/lsu_dbus_ctrl_pkg.sv
// Shared types and helpers for the memory-stage load/store unit.
//   lsu_state_t : transaction FSM states (IDLE / BUSY / DONE)
//   msize_t     : access size encoding, log2 of the byte count
//   size_bytes  : byte count of an access size
//   make_strobe : byte-enable pattern for a size at a byte offset. The result
//                 is 8 bits wide; callers on a narrower bus truncate it.
package lsu_dbus_ctrl_pkg;

   typedef enum logic [1:0] {
      LSU_IDLE = 2'd0,
      LSU_BUSY = 2'd1,
      LSU_DONE = 2'd2
   } lsu_state_t;

   typedef enum logic [1:0] {
      MSIZE_B = 2'd0,
      MSIZE_H = 2'd1,
      MSIZE_W = 2'd2,
      MSIZE_D = 2'd3
   } msize_t;

   function automatic logic [3:0] size_bytes(input logic [1:0] size);
      return 4'd1 << size;
   endfunction

   // Bytes shifted past lane 7 fall off the top of the result.
   function automatic logic [7:0] make_strobe(input logic [1:0] size, input logic [2:0] ofs);
      logic [15:0] strb;
      strb = ((16'd1 << size_bytes(size)) - 16'd1) << ofs;
      return strb[7:0];
   endfunction

endpackage

// File: rtl/lsu_dbus_ctrl_load_align.sv
// lsu_load_align: purely combinational load-data formatter.
// Shifts the raw bus word down by the byte offset, keeps the low 1/2/4/8 bytes
// and sign- or zero-extends them to the full bus width.
// Ports:
//   data_i  raw bus read data
//   ofs_i   byte offset of the access within the bus word
//   size_i  log2 of access bytes
//   zext_i  1 = zero-extend, 0 = sign-extend
//   rdata_o aligned, extended load data
module lsu_load_align
   import lsu_dbus_ctrl_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int OFS_W  = $clog2(DATA_W/8)
) (
   input  logic [DATA_W-1:0] data_i,
   input  logic [OFS_W-1:0]  ofs_i,
   input  logic [1:0]        size_i,
   input  logic              zext_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] shifted;
   logic [DATA_W-1:0] mask;
   logic              sgn;

   assign shifted = data_i >> {ofs_i, 3'b000};

   always_comb begin
      mask = '1;
      sgn  = 1'b0;
      case (size_i)
         MSIZE_B: begin
            mask = DATA_W'(8'hFF);
            sgn  = shifted[7];
         end
         MSIZE_H: begin
            mask = DATA_W'(16'hFFFF);
            sgn  = shifted[15];
         end
         MSIZE_W: begin
            mask = DATA_W'(32'hFFFF_FFFF);
            sgn  = shifted[31];
         end
         default: begin
            mask = '1;
            sgn  = 1'b0;
         end
      endcase
   end

   // Sign extension fills everything above the kept bytes with ones.
   assign rdata_o = (sgn && !zext_i) ? (shifted | ~mask) : (shifted & mask);

endmodule

// File: rtl/lsu_dbus_ctrl.sv
// lsu_dbus_ctrl: memory-stage load/store unit. Owns the data-bus request
// register and the transaction FSM, formats store data/strobes, and aligns and
// extends load data. The completed result is held in DONE until the pipeline
// advances, decoupling bus latency from downstream stalls.
//
// Build option: LSU_MISALIGN_EXC_EN - when defined, misaligned or
// lane-crossing accesses raise out_exc in IDLE instead of going to the bus.
// When undefined, out_exc is tied 0 and such accesses are issued as-is.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   in_*                   instruction from the execute/memory register
//   flush, advance         pipeline control
//   stall, out_valid,
//   out_rdata, out_exc     stage result
//   dreq_*                 registered bus request
//   dresp_*                bus response
//
// state | meaning
// IDLE  | no bus transaction; accepts a new memory instruction
// BUSY  | request outstanding on the bus; waits for addr_ok & data_ok
// DONE  | result held in out_rdata until advance or flush
module lsu_dbus_ctrl
   import lsu_dbus_ctrl_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 64,
   // Derived from DATA_W; not meant to be overridden.
   parameter int OFS_W  = $clog2(DATA_W/8)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   input  logic                in_read,
   input  logic                in_write,
   input  logic [ADDR_W-1:0]   in_addr,
   input  logic [1:0]          in_size,
   input  logic                in_zext,
   input  logic [DATA_W-1:0]   in_wdata,
   input  logic                flush,
   input  logic                advance,
   output logic                stall,
   output logic                out_valid,
   output logic [DATA_W-1:0]   out_rdata,
   output logic                out_exc,
   output logic                dreq_valid,
   output logic [ADDR_W-1:0]   dreq_addr,
   output logic [1:0]          dreq_size,
   output logic [DATA_W-1:0]   dreq_data,
   output logic [DATA_W/8-1:0] dreq_strobe,
   input  logic                dresp_addr_ok,
   input  logic                dresp_data_ok,
   input  logic [DATA_W-1:0]   dresp_data
);

   localparam int STRB_W = DATA_W/8;

   lsu_state_t        state_q;
   logic              kill_q;
   logic              is_load_q;
   logic              zext_q;

   logic              is_mem;
   logic              start_c;
   logic              done_c;
   logic              exc_c;
   logic [OFS_W-1:0]  in_ofs;
   logic [1:0]        eff_size;
   logic [DATA_W-1:0] store_data;
   logic [STRB_W-1:0] store_strobe;
   logic [DATA_W-1:0] load_data;

   assign is_mem = in_valid & (in_read | in_write);
   assign in_ofs = in_addr[OFS_W-1:0];
   assign done_c = dresp_addr_ok & dresp_data_ok;

   // An 8-byte access cannot exist on a 32-bit bus; it degrades to 4 bytes.
   assign eff_size = (DATA_W == 32 && in_size == MSIZE_D) ? MSIZE_W : in_size;

   assign store_data   = in_wdata << {in_ofs, 3'b000};
   assign store_strobe = STRB_W'(make_strobe(eff_size, 3'(in_ofs)));

`ifdef LSU_MISALIGN_EXC_EN
   logic [2:0] low_bits;
   logic       cross_c;
   assign low_bits = in_addr[2:0] & 3'(size_bytes(eff_size) - 4'd1);
   assign cross_c  = ({1'b0, 4'(in_ofs)} + {1'b0, size_bytes(eff_size)}) > 5'(STRB_W);
   assign exc_c    = (|low_bits) | cross_c;
`else
   assign exc_c    = 1'b0;
`endif

   // Load formatting uses the held request, so it stays valid for the whole
   // transaction even if the instruction inputs wander.
   lsu_load_align #(
      .DATA_W (DATA_W),
      .OFS_W  (OFS_W)
   ) u_load_align (
      .data_i  (dresp_data),
      .ofs_i   (dreq_addr[OFS_W-1:0]),
      .size_i  (dreq_size),
      .zext_i  (zext_q),
      .rdata_o (load_data)
   );

   always_comb begin
      stall     = 1'b0;
      out_valid = 1'b0;
      out_exc   = 1'b0;
      start_c   = 1'b0;
      case (state_q)
         LSU_IDLE: begin
            if (is_mem && !flush) begin
               if (exc_c) begin
                  out_valid = 1'b1;
                  out_exc   = 1'b1;
               end else begin
                  stall   = 1'b1;
                  start_c = 1'b1;
               end
            end else if (!is_mem) begin
               out_valid = in_valid;
            end
         end
         LSU_BUSY: stall = 1'b1;
         LSU_DONE: out_valid = ~flush;
         default:  stall = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= LSU_IDLE;
         kill_q      <= 1'b0;
         is_load_q   <= 1'b0;
         zext_q      <= 1'b0;
         dreq_valid  <= 1'b0;
         dreq_addr   <= '0;
         dreq_size   <= '0;
         dreq_data   <= '0;
         dreq_strobe <= '0;
         out_rdata   <= '0;
      end else begin
         case (state_q)
            LSU_IDLE: begin
               if (start_c) begin
                  dreq_valid  <= 1'b1;
                  dreq_addr   <= in_addr;
                  dreq_size   <= eff_size;
                  dreq_data   <= store_data;
                  dreq_strobe <= in_read ? '0 : store_strobe;
                  is_load_q   <= in_read;
                  zext_q      <= in_zext;
                  kill_q      <= 1'b0;
                  state_q     <= LSU_BUSY;
               end
            end
            LSU_BUSY: begin
               if (flush) begin
                  kill_q <= 1'b1;
               end
               if (done_c) begin
                  dreq_valid  <= 1'b0;
                  dreq_addr   <= '0;
                  dreq_size   <= '0;
                  dreq_data   <= '0;
                  dreq_strobe <= '0;
                  out_rdata   <= is_load_q ? load_data : '0;
                  kill_q      <= 1'b0;
                  // A flush landing on the completion cycle also kills.
                  state_q     <= (kill_q || flush) ? LSU_IDLE : LSU_DONE;
               end
            end
            LSU_DONE: begin
               if (advance || flush) begin
                  state_q <= LSU_IDLE;
               end
            end
            default: state_q <= LSU_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_dbus_ctrl.sv
module tb_lsu_dbus_ctrl;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   // 64-bit instance
   logic        a_in_valid, a_in_read, a_in_write, a_in_zext, a_flush, a_advance;
   logic [63:0] a_in_addr, a_in_wdata, a_dresp_data;
   logic [1:0]  a_in_size;
   logic        a_stall, a_out_valid, a_out_exc, a_dreq_valid;
   logic [63:0] a_out_rdata, a_dreq_addr, a_dreq_data;
   logic [1:0]  a_dreq_size;
   logic [7:0]  a_dreq_strobe;
   logic        a_addr_ok, a_data_ok;

   // 32-bit instance
   logic        b_in_valid, b_in_read, b_in_write, b_in_zext, b_flush, b_advance;
   logic [31:0] b_in_addr, b_in_wdata, b_dresp_data;
   logic [1:0]  b_in_size;
   logic        b_stall, b_out_valid, b_out_exc, b_dreq_valid;
   logic [31:0] b_out_rdata, b_dreq_addr, b_dreq_data;
   logic [1:0]  b_dreq_size;
   logic [3:0]  b_dreq_strobe;
   logic        b_addr_ok, b_data_ok;

   lsu_dbus_ctrl u_dut64 (
      .clk (clk), .reset (reset),
      .in_valid (a_in_valid), .in_read (a_in_read), .in_write (a_in_write),
      .in_addr (a_in_addr), .in_size (a_in_size), .in_zext (a_in_zext),
      .in_wdata (a_in_wdata), .flush (a_flush), .advance (a_advance),
      .stall (a_stall), .out_valid (a_out_valid), .out_rdata (a_out_rdata),
      .out_exc (a_out_exc), .dreq_valid (a_dreq_valid), .dreq_addr (a_dreq_addr),
      .dreq_size (a_dreq_size), .dreq_data (a_dreq_data), .dreq_strobe (a_dreq_strobe),
      .dresp_addr_ok (a_addr_ok), .dresp_data_ok (a_data_ok), .dresp_data (a_dresp_data)
   );

   lsu_dbus_ctrl #(.DATA_W (32), .ADDR_W (32)) u_dut32 (
      .clk (clk), .reset (reset),
      .in_valid (b_in_valid), .in_read (b_in_read), .in_write (b_in_write),
      .in_addr (b_in_addr), .in_size (b_in_size), .in_zext (b_in_zext),
      .in_wdata (b_in_wdata), .flush (b_flush), .advance (b_advance),
      .stall (b_stall), .out_valid (b_out_valid), .out_rdata (b_out_rdata),
      .out_exc (b_out_exc), .dreq_valid (b_dreq_valid), .dreq_addr (b_dreq_addr),
      .dreq_size (b_dreq_size), .dreq_data (b_dreq_data), .dreq_strobe (b_dreq_strobe),
      .dresp_addr_ok (b_addr_ok), .dresp_data_ok (b_data_ok), .dresp_data (b_dresp_data)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic clr_a();
      a_in_valid = 0; a_in_read = 0; a_in_write = 0; a_in_zext = 0;
      a_flush = 0; a_advance = 0; a_in_addr = '0; a_in_wdata = '0;
      a_in_size = 0; a_dresp_data = '0; a_addr_ok = 0; a_data_ok = 0;
   endtask

   task automatic clr_b();
      b_in_valid = 0; b_in_read = 0; b_in_write = 0; b_in_zext = 0;
      b_flush = 0; b_advance = 0; b_in_addr = '0; b_in_wdata = '0;
      b_in_size = 0; b_dresp_data = '0; b_addr_ok = 0; b_data_ok = 0;
   endtask

   task automatic load_a(input logic [63:0] addr, input logic [1:0] size, input logic zext);
      a_in_valid = 1; a_in_read = 1; a_in_write = 0;
      a_in_addr = addr; a_in_size = size; a_in_zext = zext;
   endtask

   int stall_cnt;
   int ov_seen;

   initial begin
      clr_a();
      clr_b();
      reset = 1;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_dreq_valid", a_dreq_valid, 0);
      chk("rst_dreq_addr", a_dreq_addr, 0);
      chk("rst_dreq_strobe", a_dreq_strobe, 0);
      chk("rst_out_rdata", a_out_rdata, 0);
      chk("rst_stall", a_stall, 0);
      chk("rst_out_exc", a_out_exc, 0);
      @(negedge clk);
      reset = 0;

      // signed byte load at offset 3, same-cycle completion
      stall_cnt = 0;
      load_a(64'h1003, 2'd0, 1'b0);
      #1 chk("t1_stall_idle", a_stall, 1); stall_cnt += int'(a_stall);
      @(negedge clk);
      a_addr_ok = 1; a_data_ok = 1; a_dresp_data = 64'h0000_0000_8000_0000;
      #1 chk("t1_dreq_valid", a_dreq_valid, 1);
      chk("t1_strobe", a_dreq_strobe, 8'h00);
      chk("t1_dreq_addr", a_dreq_addr, 64'h1003);
      stall_cnt += int'(a_stall);
      @(negedge clk);
      a_addr_ok = 0; a_data_ok = 0; a_advance = 1;
      #1 chk("t1_out_valid", a_out_valid, 1);
      chk("t1_rdata", a_out_rdata, 64'hFFFF_FFFF_FFFF_FF80);
      chk("t1_dreq_cleared", a_dreq_valid, 0);
      stall_cnt += int'(a_stall);
      chk("t1_stall_cycles", 64'(stall_cnt), 2);
      @(negedge clk);
      clr_a();
      #1 chk("t1_idle_ov", a_out_valid, 0);

      // halfword store at offset 6, addr_ok alone for 3 cycles
      @(negedge clk);
      a_in_valid = 1; a_in_write = 1; a_in_addr = 64'h6; a_in_size = 2'd1;
      a_in_wdata = 64'hBEEF;
      #1 chk("t2_stall_idle", a_stall, 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         a_addr_ok = 1; a_data_ok = 0;
         #1 chk("t2_hold_data", a_dreq_data, 64'hBEEF_0000_0000_0000);
         chk("t2_hold_strobe", a_dreq_strobe, 8'hC0);
         chk("t2_hold_valid", a_dreq_valid, 1);
         chk("t2_hold_stall", a_stall, 1);
      end
      @(negedge clk);
      a_data_ok = 1;
      #1 chk("t2_last_valid", a_dreq_valid, 1);
      chk("t2_last_size", a_dreq_size, 1);
      @(negedge clk);
      a_addr_ok = 0; a_data_ok = 0; a_advance = 1;
      #1 chk("t2_clr_valid", a_dreq_valid, 0);
      chk("t2_clr_data", a_dreq_data, 0);
      chk("t2_clr_strobe", a_dreq_strobe, 0);
      chk("t2_store_rdata", a_out_rdata, 0);
      chk("t2_out_valid", a_out_valid, 1);
      @(negedge clk);
      clr_a();

      // signed word load, result held in DONE while advance is low
      load_a(64'h4, 2'd2, 1'b0);
      #1 chk("t3_stall_idle", a_stall, 1);
      @(negedge clk);
      a_addr_ok = 1; a_data_ok = 1; a_dresp_data = 64'h8765_4321_0000_0000;
      @(negedge clk);
      a_addr_ok = 0; a_data_ok = 0; a_advance = 0;
      for (int i = 0; i < 4; i++) begin
         #1 chk("t3_hold_ov", a_out_valid, 1);
         chk("t3_hold_rdata", a_out_rdata, 64'hFFFF_FFFF_8765_4321);
         chk("t3_hold_noreq", a_dreq_valid, 0);
         chk("t3_hold_stall", a_stall, 0);
         @(negedge clk);
      end
      a_advance = 1;
      #1 chk("t3_adv_ov", a_out_valid, 1);
      @(negedge clk);
      a_advance = 0;

      // flush in second BUSY cycle, completion two cycles later
      ov_seen = 0;
      load_a(64'h8, 2'd3, 1'b1);
      #1 chk("t3_idle_after_adv", a_stall, 1);
      @(negedge clk);
      #1 chk("t4_b1_stall", a_stall, 1); ov_seen += int'(a_out_valid);
      @(negedge clk);
      a_flush = 1;
      #1 chk("t4_b2_stall", a_stall, 1); ov_seen += int'(a_out_valid);
      @(negedge clk);
      a_flush = 0;
      #1 chk("t4_b3_stall", a_stall, 1); ov_seen += int'(a_out_valid);
      @(negedge clk);
      a_addr_ok = 1; a_data_ok = 1; a_dresp_data = 64'h1111_2222_3333_4444;
      #1 chk("t4_b4_stall", a_stall, 1); ov_seen += int'(a_out_valid);
      @(negedge clk);
      clr_a();
      #1 chk("t4_after_stall", a_stall, 0);
      chk("t4_after_noreq", a_dreq_valid, 0);
      ov_seen += int'(a_out_valid);
      @(negedge clk);
      load_a(64'h10, 2'd3, 1'b1);
      #1 chk("t4_back_idle", a_stall, 1); ov_seen += int'(a_out_valid);
      @(negedge clk);
      a_addr_ok = 1; a_data_ok = 1; a_dresp_data = 64'hDEAD_BEEF_0123_4567;
      #1 ov_seen += int'(a_out_valid);
      @(negedge clk);
      a_addr_ok = 0; a_data_ok = 0; a_advance = 1;
      #1 chk("t4_next_rdata", a_out_rdata, 64'hDEAD_BEEF_0123_4567);
      chk("t4_ov_never", 64'(ov_seen), 0);
      @(negedge clk);
      clr_a();

      // non-memory instruction passes through
      a_in_valid = 1;
      #1 chk("t5_nonmem_ov", a_out_valid, 1);
      chk("t5_nonmem_stall", a_stall, 0);
      @(negedge clk);
      clr_a();
      #1 chk("t5_nonmem_noreq", a_dreq_valid, 0);

      // flush in IDLE suppresses the request
      @(negedge clk);
      load_a(64'h18, 2'd3, 1'b0);
      a_flush = 1;
      #1 chk("t6_flush_stall", a_stall, 0);
      chk("t6_flush_ov", a_out_valid, 0);
      @(negedge clk);
      clr_a();
      #1 chk("t6_flush_noreq", a_dreq_valid, 0);

      // misaligned word access at offset 2
      @(negedge clk);
`ifdef LSU_MISALIGN_EXC_EN
      load_a(64'h2, 2'd2, 1'b0);
      #1 chk("t7_exc", a_out_exc, 1);
      chk("t7_exc_ov", a_out_valid, 1);
      chk("t7_exc_stall", a_stall, 0);
      @(negedge clk);
      clr_a();
      #1 chk("t7_exc_noreq", a_dreq_valid, 0);
`else
      a_in_valid = 1; a_in_write = 1; a_in_addr = 64'h2; a_in_size = 2'd2;
      a_in_wdata = 64'hAABB_CCDD;
      #1 chk("t7_noexc", a_out_exc, 0);
      chk("t7_stall", a_stall, 1);
      @(negedge clk);
      a_addr_ok = 1; a_data_ok = 1;
      #1 chk("t7_strobe", a_dreq_strobe, 8'h3C);
      chk("t7_data", a_dreq_data, 64'h0000_AABB_CCDD_0000);
      chk("t7_valid", a_dreq_valid, 1);
      @(negedge clk);
      a_addr_ok = 0; a_data_ok = 0; a_advance = 1;
      #1 chk("t7_done_ov", a_out_valid, 1);
      @(negedge clk);
      clr_a();
`endif

      // reset while BUSY abandons the request
      @(negedge clk);
      load_a(64'h20, 2'd3, 1'b0);
      @(negedge clk);
      reset = 1;
      #1 chk("t8_busy_valid", a_dreq_valid, 1);
      @(negedge clk);
      reset = 0;
      clr_a();
      #1 chk("t8_rst_noreq", a_dreq_valid, 0);
      chk("t8_rst_addr", a_dreq_addr, 0);
      chk("t8_rst_stall", a_stall, 0);

      // 32-bit bus: zero-extended word load, and size-3 clamp
      @(negedge clk);
      b_in_valid = 1; b_in_read = 1; b_in_addr = 32'h4; b_in_size = 2'd2; b_in_zext = 1;
      #1 chk("t9_stall", b_stall, 1);
      @(negedge clk);
      b_addr_ok = 1; b_data_ok = 1; b_dresp_data = 32'h8000_0001;
      #1 chk("t9_strobe", b_dreq_strobe, 4'h0);
      chk("t9_addr", b_dreq_addr, 32'h4);
      chk("t9_size", b_dreq_size, 2);
      @(negedge clk);
      b_addr_ok = 0; b_data_ok = 0; b_advance = 1;
      #1 chk("t9_rdata", b_out_rdata, 32'h8000_0001);
      chk("t9_ov", b_out_valid, 1);
      @(negedge clk);
      clr_b();
      b_in_valid = 1; b_in_read = 1; b_in_addr = 32'h8; b_in_size = 2'd3;
      @(negedge clk);
      b_addr_ok = 1; b_data_ok = 1; b_dresp_data = 32'hF000_0000;
      #1 chk("t9_clamp_size", b_dreq_size, 2);
      @(negedge clk);
      b_addr_ok = 0; b_data_ok = 0; b_advance = 1;
      #1 chk("t9_clamp_rdata", b_out_rdata, 32'hF000_0000);
      @(negedge clk);
      clr_b();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
